// File: rtl/bcd_converter_if.sv
// Handshake and result bus between the score logic, the binary-to-BCD
// converter and the seven-segment digit multiplexer.
interface bcd_converter_if #(
  parameter int W      = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [W-1:0]          binary_in;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
  logic                  neg;
  logic                  overflow;
  logic                  busy;
  logic                  done;

  modport master (
    output start, binary_in,
    input  bcd, blank, neg, overflow, busy, done
  );

  modport slave (
    input  start, binary_in,
    output bcd, blank, neg, overflow, busy, done
  );
endinterface

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle, with
// optional two's-complement input, overflow detection and leading-zero blanking.
module bcd_converter #(
  parameter int W      = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  bcd_converter_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(W);
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic               load, finish;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       op_q;
  logic [BCD_W-1:0]   scratch_q;
  logic               ovf_q, sign_q, nz_q;

  logic [W-1:0]       mag;
  logic               sign_in;
  logic [BCD_W-1:0]   adj, scratch_nxt;
  logic               ovf_nxt;
  logic [DIGITS-1:0]  blank_nxt;
  logic               run_zero;

  logic [BCD_W-1:0]   bcd_r;
  logic [DIGITS-1:0]  blank_r;
  logic               neg_r, ovf_r, done_r;

  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Most negative input maps to 2^(W-1), which still fits W unsigned bits.
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
    logic signed [W-1:0] n;
    n = -v;
    return v[W-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  assign sign_in = SIGNED && bus.binary_in[W-1];
  assign mag     = SIGNED ? magnitude(bus.binary_in) : bus.binary_in;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = dabble(scratch_q[4*i +: 4]);
    end
    scratch_nxt = {adj[BCD_W-2:0], op_q[W-1]};
    // A bit leaving the top digit means the value no longer fits.
    ovf_nxt     = ovf_q | adj[BCD_W-1];

    blank_nxt = '0;
    run_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero     = run_zero & (scratch_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = run_zero;
    end
    if (ovf_nxt) begin
      blank_nxt = '0;
    end
  end

  // Operand/scratch datapath: loaded on accept, shifted each SHIFT cycle
  always_ff @(posedge clk) begin
    if (load) begin
      op_q      <= mag;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      sign_q    <= sign_in;
      nz_q      <= |mag;
      cnt       <= CNT_W'(W - 1);
    end else if (state == SHIFT) begin
      op_q      <= op_q << 1;
      scratch_q <= scratch_nxt;
      ovf_q     <= ovf_nxt;
      cnt       <= cnt - 1'b1;
    end
  end

  // Control and result registers; results only change on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done_r  <= 1'b0;
      bcd_r   <= '0;
      blank_r <= BLANK_RST;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= finish;
      if (finish) begin
        bcd_r   <= scratch_nxt;
        blank_r <= blank_nxt;
        neg_r   <= sign_q & nz_q;
        ovf_r   <= ovf_nxt;
      end
    end
  end

  assign bus.bcd      = bcd_r;
  assign bus.blank    = blank_r;
  assign bus.neg      = neg_r;
  assign bus.overflow = ovf_r;
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = done_r;
endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter in three configurations: 16-bit/5-digit,
// 16-bit/3-digit and signed 8-bit/3-digit.
module tb_bcd_converter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bcd_converter_if #(.W(16), .DIGITS(5)) ia ();
  bcd_converter_if #(.W(16), .DIGITS(3)) ib ();
  bcd_converter_if #(.W(8),  .DIGITS(3)) ic ();

  bcd_converter #(.W(16), .DIGITS(5), .SIGNED(1'b0)) ua (.clk(clk), .reset(reset), .bus(ia.slave));
  bcd_converter #(.W(16), .DIGITS(3), .SIGNED(1'b0)) ub (.clk(clk), .reset(reset), .bus(ib.slave));
  bcd_converter #(.W(8),  .DIGITS(3), .SIGNED(1'b1)) uc (.clk(clk), .reset(reset), .bus(ic.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    checks++;
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return ia.done;
      1:       return ib.done;
      default: return ic.done;
    endcase
  endfunction

  // Pulse start for one edge, then count cycles from that edge to done.
  task automatic run(input int sel, input logic [15:0] val, output int lat);
    case (sel)
      0:       begin ia.start = 1'b1; ia.binary_in = val;      end
      1:       begin ib.start = 1'b1; ib.binary_in = val;      end
      default: begin ic.start = 1'b1; ic.binary_in = val[7:0]; end
    endcase
    tick();
    ia.start = 1'b0;
    ib.start = 1'b0;
    ic.start = 1'b0;
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_of(sel)) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int n;
    int dones;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ia.start = 1'b0; ia.binary_in = '0;
    ib.start = 1'b0; ib.binary_in = '0;
    ic.start = 1'b0; ic.binary_in = '0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_bcd",   32'(ia.bcd),      32'h0);
    check("rst_blank", 32'(ia.blank),    32'h1E);
    check("rst_neg",   32'(ia.neg),      32'h0);
    check("rst_ovf",   32'(ia.overflow), 32'h0);
    check("rst_busy",  32'(ia.busy),     32'h0);
    check("rst_done",  32'(ia.done),     32'h0);
    check("rst_blank_c", 32'(ic.blank),  32'h6);

    // 1243 on 5 digits
    ia.start = 1'b1; ia.binary_in = 16'd1243;
    tick();
    ia.start = 1'b0;
    check("busy_after_start", 32'(ia.busy), 32'h1);
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ia.done) begin lat = i; break; end
    end
    check("lat_1243",   32'(lat),         32'd16);
    check("busy_done",  32'(ia.busy),     32'h0);
    check("bcd_1243",   32'(ia.bcd),      32'h01243);
    check("blank_1243", 32'(ia.blank),    32'h10);
    check("ovf_1243",   32'(ia.overflow), 32'h0);
    check("neg_1243",   32'(ia.neg),      32'h0);
    tick();
    check("done_pulse", 32'(ia.done),     32'h0);
    check("hold_1243",  32'(ia.bcd),      32'h01243);

    // 0 then 65535 back-to-back, second start in the done cycle
    run(0, 16'd0, lat);
    check("lat_0",     32'(lat),      32'd16);
    check("bcd_0",     32'(ia.bcd),   32'h0);
    check("blank_0",   32'(ia.blank), 32'h1E);
    run(0, 16'd65535, lat);
    check("gap_b2b",   32'(lat + 1),  32'd17);
    check("bcd_65535", 32'(ia.bcd),   32'h65535);
    check("blank_65535", 32'(ia.blank), 32'h0);
    check("ovf_65535", 32'(ia.overflow), 32'h0);

    // 3-digit overflow
    run(1, 16'd1243, lat);
    check("lat_b",       32'(lat),         32'd16);
    check("bcd_b_1243",  32'(ib.bcd),      32'h243);
    check("ovf_b_1243",  32'(ib.overflow), 32'h1);
    check("blank_b_1243", 32'(ib.blank),   32'h0);
    run(1, 16'd999, lat);
    check("bcd_b_999",   32'(ib.bcd),      32'h999);
    check("ovf_b_999",   32'(ib.overflow), 32'h0);
    check("blank_b_999", 32'(ib.blank),    32'h0);

    // Signed 8-bit
    run(2, 16'h0080, lat);
    check("lat_c",      32'(lat),      32'd8);
    check("bcd_c_m128", 32'(ic.bcd),   32'h128);
    check("neg_c_m128", 32'(ic.neg),   32'h1);
    check("blank_c_m128", 32'(ic.blank), 32'h0);
    check("ovf_c_m128", 32'(ic.overflow), 32'h0);
    run(2, 16'h00FB, lat);
    check("bcd_c_m5",   32'(ic.bcd),   32'h005);
    check("neg_c_m5",   32'(ic.neg),   32'h1);
    check("blank_c_m5", 32'(ic.blank), 32'h6);
    run(2, 16'h007F, lat);
    check("bcd_c_127",  32'(ic.bcd),   32'h127);
    check("neg_c_127",  32'(ic.neg),   32'h0);
    run(2, 16'h0000, lat);
    check("bcd_c_0",    32'(ic.bcd),   32'h000);
    check("neg_c_0",    32'(ic.neg),   32'h0);
    check("blank_c_0",  32'(ic.blank), 32'h6);

    // Start re-pulse and operand change mid-conversion are ignored
    ia.start = 1'b1; ia.binary_in = 16'd4321;
    tick();
    ia.start = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); n++; end
    ia.start = 1'b1; ia.binary_in = 16'd9999;
    tick(); n++;
    ia.start = 1'b0; ia.binary_in = 16'd1111;
    while (!ia.done && n < 40) begin tick(); n++; end
    check("lat_ignore", 32'(n),      32'd16);
    check("bcd_ignore", 32'(ia.bcd), 32'h04321);
    dones = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (ia.done) dones++; end
    check("single_done", 32'(dones), 32'd0);

    // Reset during a conversion aborts it
    ia.start = 1'b1; ia.binary_in = 16'd777;
    tick();
    ia.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",  32'(ia.busy),     32'h0);
    check("abort_done",  32'(ia.done),     32'h0);
    check("abort_bcd",   32'(ia.bcd),      32'h0);
    check("abort_blank", 32'(ia.blank),    32'h1E);
    check("abort_ovf",   32'(ia.overflow), 32'h0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (ia.done) dones++; end
    check("abort_no_done", 32'(dones), 32'd0);
    run(0, 16'd50000, lat);
    check("lat_50000",   32'(lat),      32'd16);
    check("bcd_50000",   32'(ia.bcd),   32'h50000);
    check("blank_50000", 32'(ia.blank), 32'h0);

    // Reset and start on the same edge: reset wins
    reset = 1'b1; ic.start = 1'b1; ic.binary_in = 8'h05;
    tick();
    reset = 1'b0; ic.start = 1'b0;
    check("rst_wins_busy", 32'(ic.busy), 32'h0);
    tick();
    check("rst_wins_idle", 32'(ic.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
